// File: rtl/enigma_pkg.sv
// Shared types and constants for the three-rotor Enigma I datapath:
// FSM state encoding, letter index type, notch positions and mod-26 helpers.
package enigma_pkg;

  localparam int MOD = 26;

  typedef logic [4:0] letter_t;

  typedef enum logic [3:0] {
    IDLE, STEP, F1, F2, F3, REFL, B1, B2, B3, HOLD
  } state_t;

  localparam letter_t NOTCH_I   = 5'd16;
  localparam letter_t NOTCH_II  = 5'd4;
  localparam letter_t NOTCH_III = 5'd21;

  // Rotor select value that routes the shared lookup to reflector B.
  localparam logic [1:0] SEL_REFL = 2'd3;

  function automatic letter_t notch_of(input int sel);
    case (sel)
      0:       return NOTCH_I;
      1:       return NOTCH_II;
      default: return NOTCH_III;
    endcase
  endfunction

  function automatic letter_t add26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(MOD)) s = s - 6'(MOD);
    return s[4:0];
  endfunction

  function automatic letter_t sub26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + 6'(MOD) - {1'b0, b};
    if (s >= 6'(MOD)) s = s - 6'(MOD);
    return s[4:0];
  endfunction

  function automatic letter_t inc26(input letter_t a);
    return (a == letter_t'(MOD - 1)) ? '0 : a + 5'd1;
  endfunction

endpackage

// File: rtl/enigma_rotor_lut.sv
// Combinational wiring lookup for rotors I/II/III (forward or inverse) and
// reflector B; position offsets are applied by the caller.
module rotor_lut
  import enigma_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic       i_inv,
  input  letter_t    i_idx,
  output letter_t    o_idx
);

  localparam logic [8*26-1:0] W_I    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] W_II   = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [8*26-1:0] W_III  = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*26-1:0] W_REFL = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  // First character of a string literal sits in the top byte.
  function automatic letter_t fwd(input logic [1:0] sel, input letter_t c);
    int         k;
    logic [7:0] ch;
    k = (c > letter_t'(MOD - 1)) ? 0 : (MOD - 1) - int'(c);
    case (sel)
      2'd0:    ch = W_I[8*k +: 8];
      2'd1:    ch = W_II[8*k +: 8];
      2'd2:    ch = W_III[8*k +: 8];
      default: ch = W_REFL[8*k +: 8];
    endcase
    return letter_t'(ch - 8'd65);
  endfunction

  always_comb begin
    o_idx = '0;
    if (!i_inv) begin
      o_idx = fwd(i_sel, i_idx);
    end else begin
      for (int k = 0; k < MOD; k++)
        if (fwd(i_sel, letter_t'(k)) == i_idx) o_idx = letter_t'(k);
    end
  end

endmodule

// File: rtl/enigma_core.sv
// Sequential Enigma I encipherer: one rotor/reflector pass per cycle through a
// single shared lookup, lamp held until the key is released.
module enigma_core
  import enigma_pkg::*;
#(
  parameter int ROTOR_L = 0,
  parameter int ROTOR_M = 1,
  parameter int ROTOR_R = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] key_in,
  input  logic [2:0]  rot_inc,
  output logic [25:0] lamp,
  output logic [4:0]  state1,
  output logic [4:0]  state2,
  output logic [4:0]  state3,
  output logic        busy,
  output logic        done
);

  state_t      r_state, w_next;
  letter_t     r_idx, r_pos1, r_pos2, r_pos3;
  logic [25:0] r_lamp;
  logic        r_done;

  logic        w_valid, w_inv, w_r_notch, w_m_notch;
  letter_t     w_key_idx, w_pos, w_lut_in, w_lut_out, w_res;
  logic [1:0]  w_sel;

  assign w_valid = $onehot(key_in);

  always_comb begin
    w_key_idx = '0;
    for (int k = 0; k < MOD; k++)
      if (key_in[k]) w_key_idx = letter_t'(k);
  end

  assign w_r_notch = (r_pos1 == notch_of(ROTOR_R));
  assign w_m_notch = (r_pos2 == notch_of(ROTOR_M));

  // Route the shared lookup to the rotor and position of the current pass.
  always_comb begin
    w_sel = 2'(ROTOR_R);
    w_inv = 1'b0;
    w_pos = '0;
    case (r_state)
      F1:      begin w_sel = 2'(ROTOR_R); w_pos = r_pos1; end
      F2:      begin w_sel = 2'(ROTOR_M); w_pos = r_pos2; end
      F3:      begin w_sel = 2'(ROTOR_L); w_pos = r_pos3; end
      REFL:    begin w_sel = SEL_REFL; end
      B1:      begin w_sel = 2'(ROTOR_L); w_pos = r_pos3; w_inv = 1'b1; end
      B2:      begin w_sel = 2'(ROTOR_M); w_pos = r_pos2; w_inv = 1'b1; end
      B3:      begin w_sel = 2'(ROTOR_R); w_pos = r_pos1; w_inv = 1'b1; end
      default: ;
    endcase
  end

  assign w_lut_in = add26(r_idx, w_pos);
  assign w_res    = sub26(w_lut_out, w_pos);

  rotor_lut u_lut (
    .i_sel (w_sel),
    .i_inv (w_inv),
    .i_idx (w_lut_in),
    .o_idx (w_lut_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next = STEP;
      STEP:    w_next = F1;
      F1:      w_next = F2;
      F2:      w_next = F3;
      F3:      w_next = REFL;
      REFL:    w_next = B1;
      B1:      w_next = B2;
      B2:      w_next = B3;
      B3:      w_next = HOLD;
      HOLD:    if (key_in == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pos1 <= '0;
      r_pos2 <= '0;
      r_pos3 <= '0;
      r_lamp <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == B3);
      case (r_state)
        IDLE: if (!w_valid) begin
          if (rot_inc[0]) r_pos1 <= inc26(r_pos1);
          if (rot_inc[1]) r_pos2 <= inc26(r_pos2);
          if (rot_inc[2]) r_pos3 <= inc26(r_pos3);
        end
        // Notch decisions use pre-step positions, giving the middle double step.
        STEP: begin
          r_pos1 <= inc26(r_pos1);
          if (w_r_notch || w_m_notch) r_pos2 <= inc26(r_pos2);
          if (w_m_notch) r_pos3 <= inc26(r_pos3);
        end
        B3:   r_lamp <= 26'(1) << w_res;
        HOLD: if (key_in == '0) r_lamp <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_valid) r_idx <= w_key_idx;
    else if (r_state inside {F1, F2, F3, REFL, B1, B2}) r_idx <= w_res;
  end

  assign lamp   = r_lamp;
  assign done   = r_done;
  assign state1 = r_pos1;
  assign state2 = r_pos2;
  assign state3 = r_pos3;

endmodule

// File: tb/tb_enigma_core.sv
// Directed bench for enigma_core with a reference cipher model and a lamp scoreboard.
module tb_enigma_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [25:0] key_in = '0;
  logic [2:0]  rot_inc = '0;
  logic [25:0] lamp;
  logic [4:0]  state1, state2, state3;
  logic        busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int m1 = 0, m2 = 0, m3 = 0;
  logic [25:0] sb_q[$];

  string WR[4] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                   "BDFHJLCPRTXVZNYEIWGAKMUSQO", "YRUHQSLDPXNGOKMIEBFZCWVJAT"};

  enigma_core dut (
    .clk(clk), .reset(reset), .key_in(key_in), .rot_inc(rot_inc),
    .lamp(lamp), .state1(state1), .state2(state2), .state3(state3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int wmap(input int sel, input int i);
    string s;
    s = WR[sel];
    return int'(s[i]) - 65;
  endfunction

  function automatic int pass_f(input int sel, input int c, input int p);
    return (wmap(sel, (c + p) % 26) - p + 26) % 26;
  endfunction

  function automatic int pass_b(input int sel, input int c, input int p);
    int t;
    t = (c + p) % 26;
    for (int i = 0; i < 26; i++)
      if (wmap(sel, i) == t) return (i - p + 26) % 26;
    return -1;
  endfunction

  // Right=III (sel 2, notch V), middle=II (sel 1, notch E), left=I (sel 0).
  function automatic int model_press(input int c);
    int x;
    bit rn, mn;
    rn = (m1 == 21);
    mn = (m2 == 4);
    m1 = (m1 + 1) % 26;
    if (rn || mn) m2 = (m2 + 1) % 26;
    if (mn) m3 = (m3 + 1) % 26;
    x = pass_f(2, c, m1);
    x = pass_f(1, x, m2);
    x = pass_f(0, x, m3);
    x = pass_f(3, x, 0);
    x = pass_b(0, x, m3);
    x = pass_b(1, x, m2);
    x = pass_b(2, x, m1);
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m1 = 0; m2 = 0; m3 = 0;
  endtask

  task automatic apply_inc(input logic [2:0] bits, input int n);
    rot_inc = bits;
    repeat (n) @(negedge clk);
    rot_inc = '0;
    if (bits[0]) m1 = (m1 + n) % 26;
    if (bits[1]) m2 = (m2 + n) % 26;
    if (bits[2]) m3 = (m3 + n) % 26;
  endtask

  // Called at a negedge. exp_l >= 0 overrides the model's lamp letter.
  task automatic press(input int c, input int exp_l, input int hold, input logic [2:0] inc);
    int cyc, got, e;
    logic [25:0] exp_lamp, held;
    key_in  = 26'(1) << c;
    rot_inc = inc;
    e = model_press(c);
    if (exp_l >= 0) e = exp_l;
    sb_q.push_back(26'(1) << e);
    cyc = 0; got = 0;
    while (cyc < 20 && got == 0) begin
      @(negedge clk);
      rot_inc = '0;
      cyc++;
      if (done) got = 1;
    end
    check("done_seen", 64'(got), 64'd1);
    if (got != 0) begin
      check("done_latency", 64'(cyc), 64'd9);
      exp_lamp = sb_q.pop_front();
      check("lamp", 64'(lamp), 64'(exp_lamp));
      check("positions", {49'd0, state3, state2, state1},
            {49'd0, 5'(m3), 5'(m2), 5'(m1)});
    end
    held = lamp;
    for (int h = 0; h < hold; h++) begin
      if (h == 1) key_in = 26'(1) << ((c + 7) % 26);
      @(negedge clk);
      check("hold_lamp", 64'(lamp), 64'(held));
      check("hold_done_low", 64'(done), 64'd0);
    end
    key_in = '0;
    @(negedge clk);
    check("release_dark", {37'd0, lamp, busy}, 64'd0);
  endtask

  initial begin
    // Reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("reset_idle", {21'd0, state3, state2, state1, lamp, busy, done}, 64'd0);
      @(negedge clk);
    end

    // AAAAA from AAA -> BDZGO; first press also exercises hold with key change
    press(0, 1, 3, 3'b000);
    press(0, 3, 0, 3'b000);
    press(0, 25, 0, 3'b000);
    press(0, 6, 0, 3'b000);
    press(0, 14, 0, 3'b000);
    check("state1_after5", 64'(state1), 64'd5);

    // Double step from ADU
    do_reset();
    apply_inc(3'b011, 3);
    apply_inc(3'b001, 17);
    check("set_ADU", {49'd0, state3, state2, state1}, {49'd0, 5'd0, 5'd3, 5'd20});
    press(7, -1, 0, 3'b000);
    check("pos_ADV", {49'd0, state3, state2, state1}, {49'd0, 5'd0, 5'd3, 5'd21});
    press(4, -1, 0, 3'b000);
    check("pos_AEW", {49'd0, state3, state2, state1}, {49'd0, 5'd0, 5'd4, 5'd22});
    press(11, -1, 0, 3'b000);
    check("pos_BFX", {49'd0, state3, state2, state1}, {49'd0, 5'd1, 5'd5, 5'd23});

    // Multi-hot ignored; key beats simultaneous rot_inc
    key_in = 26'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("multihot_idle", {48'd0, busy, state3, state2, state1},
            {48'd0, 1'b0, 5'(m3), 5'(m2), 5'(m1)});
    end
    key_in = '0;
    @(negedge clk);
    press(2, -1, 0, 3'b001);
    check("key_wins_state1", 64'(state1), 64'd24);

    // Reset during F2 with key held; key captured on first edge after release
    key_in = 26'(1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_midrun", {21'd0, state3, state2, state1, lamp, busy, done}, 64'd0);
    m1 = 0; m2 = 0; m3 = 0;
    reset = 1'b1;
    press(0, 1, 0, 3'b000);

    // rot_inc wrap 25 -> 0
    do_reset();
    apply_inc(3'b111, 25);
    check("pos_25", {49'd0, state3, state2, state1}, {49'd0, 5'd25, 5'd25, 5'd25});
    apply_inc(3'b111, 1);
    check("pos_wrap", {49'd0, state3, state2, state1}, 64'd0);
    check("wrap_no_lamp", {37'd0, lamp, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
